// File: rtl/operand_serial_loader_if.sv
// Bus bundle for the serial operand loader: load control, serial bit stream,
// consumer acknowledge, the operand words/enable that feed the gating stage,
// and a debug view of the loader's FSM state and bit counter.
//
// Handshake: a serial bit moves on a rising clk edge only when ser_valid=1 and
// ser_ready=1 in that cycle; ser_in is ignored while ser_valid=0, and
// ser_valid is ignored while ser_ready=0. The producer may drop ser_valid at
// any time (stall); the loader never consumes a bit without ser_ready.
interface operand_serial_loader_if #(
  parameter int n = 4
) ();
  localparam int CW = $clog2(n);

  logic          start;
  logic          clear;
  logic          ser_in;
  logic          ser_valid;
  logic          ser_ready;
  logic          ack;
  logic [n-1:0]  word_a;
  logic [n-1:0]  word_b;
  logic          word_en;
  logic          busy;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_count;

  // Producer/consumer side driving the loader.
  modport master (
    output start, clear, ser_in, ser_valid, ack,
    input  ser_ready, word_a, word_b, word_en, busy, dbg_state, dbg_count
  );

  // The loader itself.
  modport slave (
    input  start, clear, ser_in, ser_valid, ack,
    output ser_ready, word_a, word_b, word_en, busy, dbg_state, dbg_count
  );
endinterface

// File: rtl/operand_serial_loader.sv
// Serial-in operand capture stage. Shifts word A then word B in LSB first,
// then holds both words with word_en high until the consumer acknowledges.
// Every output comes straight from a register, so no input reaches an output
// combinationally.
module operand_serial_loader #(
  parameter int n = 4
) (
  input logic                    clk,
  input logic                    reset,
  operand_serial_loader_if.slave bus
);
  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [n-1:0]  word_a_q;
  logic [n-1:0]  word_b_q;
  logic          word_en_q;
  logic          ser_ready_q;
  logic          busy_q;
  logic          bit_acc;

  // A bit is consumed only when both sides agree in this cycle.
  assign bit_acc = bus.ser_valid & ser_ready_q;
  assign cnt_d   = cnt_q + CW'(1);

  // Load FSM; status flags are registered alongside each state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_a_q    <= '0;
      word_b_q    <= '0;
      word_en_q   <= 1'b0;
      ser_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.clear) begin
      // Abort wins over start, ack and any bit in flight.
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_a_q    <= '0;
      word_b_q    <= '0;
      word_en_q   <= 1'b0;
      ser_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            word_a_q    <= '0;
            word_b_q    <= '0;
            ser_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        LOAD_A: begin
          if (bit_acc) begin
            word_a_q[cnt_q] <= bus.ser_in;
            if (cnt_q == LAST) begin
              state_q <= LOAD_B;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        LOAD_B: begin
          if (bit_acc) begin
            word_b_q[cnt_q] <= bus.ser_in;
            if (cnt_q == LAST) begin
              state_q     <= HOLD;
              cnt_q       <= '0;
              ser_ready_q <= 1'b0;
              word_en_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        HOLD: begin
          // Words stay put after ack; only start or clear changes them.
          if (bus.ack) begin
            state_q   <= IDLE;
            word_en_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          word_en_q   <= 1'b0;
          ser_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ser_ready = ser_ready_q;
  assign bus.word_a    = word_a_q;
  assign bus.word_b    = word_b_q;
  assign bus.word_en   = word_en_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_count = cnt_q;
endmodule

// File: tb/tb_operand_serial_loader.sv
// Bench for operand_serial_loader. A bit-queue reference model tracks the
// load phase and the accepted bit stream; expected operand pairs also flow
// through a scoreboard queue that is drained when the words are held.
module tb_operand_serial_loader;
  localparam int N  = 4;
  localparam int CW = $clog2(N);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  operand_serial_loader_if #(.n(N)) bus ();

  operand_serial_loader #(.n(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: phase 0 idle, 1 loading A, 2 loading B, 3 holding.
  int   m_phase;
  logic m_bits[$];
  logic [2*N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_word(input int base);
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++)
      if (base + i < m_bits.size()) w[i] = m_bits[base + i];
    return w;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_bits.delete();
  endtask

  // One rising edge as seen by the model, using the inputs the bench drives.
  task automatic model_edge();
    if (bus.clear) begin
      m_phase = 0;
      m_bits.delete();
    end else begin
      case (m_phase)
        0: if (bus.start) begin m_phase = 1; m_bits.delete(); end
        1, 2: if (bus.ser_valid) begin
          m_bits.push_back(bus.ser_in);
          if (m_bits.size() == N) m_phase = 2;
          else if (m_bits.size() == 2 * N) m_phase = 3;
        end
        3: if (bus.ack) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".word_a"},    32'(bus.word_a),    32'(m_word(0)));
    chk({tag, ".word_b"},    32'(bus.word_b),    32'(m_word(N)));
    chk({tag, ".word_en"},   32'(bus.word_en),   32'(m_phase == 3));
    chk({tag, ".ser_ready"}, 32'(bus.ser_ready), 32'(m_phase == 1 || m_phase == 2));
    chk({tag, ".busy"},      32'(bus.busy),      32'(m_phase != 0));
    chk({tag, ".state"},     32'(bus.dbg_state), 32'(m_phase));
    chk({tag, ".count"},     32'(bus.dbg_count), 32'(m_bits.size() % N));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ack       = 1'b0;
    bus.ser_in    = 1'($urandom_range(0, 1));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  // gap_mode: 0 no stalls, 1 valid low every other cycle, 2 random stalls.
  // nbits < 2N leaves the load unfinished.
  task automatic load_pair(input logic [N-1:0] a, input logic [N-1:0] b,
                           input int gap_mode, input int nbits, input string tag);
    int t0;
    int stalls;
    int g;
    bus.start = 1'b1;
    step({tag, ".start"});
    bus.start = 1'b0;
    t0 = cyc;
    stalls = 0;
    for (int i = 0; i < nbits; i++) begin
      g = (gap_mode == 1) ? int'(i > 0) : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        bus.ser_valid = 1'b0;
        bus.ser_in    = 1'($urandom_range(0, 1));
        stalls++;
        step({tag, ".stall"});
      end
      bus.ser_valid = 1'b1;
      bus.ser_in    = (i < N) ? a[i] : b[i - N];
      step({tag, ".bit"});
    end
    bus.ser_valid = 1'b0;
    if (nbits == 2 * N) begin
      exp_q.push_back({b, a});
      chk({tag, ".latency"}, 32'(cyc - t0), 32'(2 * N + stalls));
    end
  endtask

  // Scoreboard: the held words must match the pair that was sent.
  task automatic hold_check(input string tag);
    logic [2*N-1:0] e;
    chk({tag, ".sb_nonempty"}, 32'(exp_q.size() != 0), 32'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".sb_words"}, 32'({bus.word_b, bus.word_a}), 32'(e));
      chk({tag, ".sb_en"}, 32'(bus.word_en), 32'(1));
    end
  endtask

  task automatic hold_noise(input int cycles, input string tag);
    repeat (cycles) begin
      bus.start     = 1'($urandom_range(0, 1));
      bus.ser_valid = 1'($urandom_range(0, 1));
      bus.ser_in    = 1'($urandom_range(0, 1));
      step({tag, ".noise"});
    end
    idle_inputs();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    idle_inputs();
    model_reset();

    // Reset asserted before any clock edge: outputs must clear asynchronously.
    #2 reset = 1'b1;
    #1 check_outputs("reset_async");
    @(posedge clk);
    #1 check_outputs("reset_held");
    #2 reset = 1'b0;
    step("post_reset_idle");

    // Full-rate load: A=1101, B=0110, word_en 2N+1 cycles after start.
    load_pair(4'b1101, 4'b0110, 0, 2 * N, "full_rate");
    chk("full_rate.a_val", 32'(bus.word_a), 32'(4'b1101));
    chk("full_rate.b_val", 32'(bus.word_b), 32'(4'b0110));
    hold_check("full_rate");

    // Start/serial noise in HOLD changes nothing, then ack releases.
    hold_noise(3, "hold");
    bus.ack = 1'b1;
    step("ack");
    idle_inputs();
    chk("ack.word_en", 32'(bus.word_en), 32'(0));
    chk("ack.busy", 32'(bus.busy), 32'(0));
    chk("ack.a_kept", 32'(bus.word_a), 32'(4'b1101));
    chk("ack.b_kept", 32'(bus.word_b), 32'(4'b0110));
    step("idle_after_ack");

    // Same stream with valid low every other cycle.
    load_pair(4'b1101, 4'b0110, 1, 2 * N, "gappy");
    hold_check("gappy");
    bus.ack = 1'b1;
    step("gappy_ack");
    idle_inputs();

    // Clear after two bits of B.
    load_pair(4'b1011, 4'b0101, 0, N + 2, "partial");
    bus.clear = 1'b1;
    step("clear_mid_b");
    idle_inputs();
    chk("clear.word_a", 32'(bus.word_a), 32'(0));
    chk("clear.state", 32'(bus.dbg_state), 32'(0));
    load_pair(4'b0011, 4'b1100, 0, 2 * N, "after_clear");
    hold_check("after_clear");

    // clear beats ack in HOLD.
    bus.clear = 1'b1;
    bus.ack   = 1'b1;
    step("clear_ack");
    idle_inputs();
    chk("clear_ack.word_b", 32'(bus.word_b), 32'(0));

    // clear beats start in IDLE.
    bus.clear = 1'b1;
    bus.start = 1'b1;
    step("clear_start");
    idle_inputs();
    chk("clear_start.busy", 32'(bus.busy), 32'(0));

    // Async reset between edges mid-LOAD_A.
    load_pair(4'b1111, 4'b1111, 0, 2, "pre_reset");
    #3 reset = 1'b1;
    model_reset();
    #1 check_outputs("reset_mid_load");
    @(posedge clk);
    #1 check_outputs("reset_mid_held");
    #2 reset = 1'b0;
    bus.ack = 1'b1;
    step("reset_idle0");
    bus.ack = 1'b0;
    step("reset_idle1");

    // Random loads with random stalls, hold noise and ack delay.
    for (int k = 0; k < 10; k++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      load_pair(ra, rb, 2, 2 * N, "rand");
      hold_check("rand");
      hold_noise($urandom_range(0, 3), "rand_hold");
      bus.ack = 1'b1;
      step("rand_ack");
      idle_inputs();
      repeat ($urandom_range(0, 2)) begin
        bus.ack = 1'($urandom_range(0, 1));
        step("rand_idle");
      end
      idle_inputs();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
